// File: rtl/packet_error_filter.sv
// Second-stage RDMA receive filter: pops one BPI entry per packet, forwards good packets
// to AXIS_OUT with zero latency and drains bad packets at full rate, keeping statistics.
module packet_error_filter #(
    parameter int DATA_WBITS = 512,
    parameter int DATA_WBYTS = DATA_WBITS / 8,
    parameter int BPI_WBITS  = 8,
    parameter int CNT_WBITS  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [BPI_WBITS-1:0]  error_mask,
    input  logic                  clear_stats,
    output logic                  bad_pkt_dropped,
    output logic [CNT_WBITS-1:0]  good_pkt_count,
    output logic [CNT_WBITS-1:0]  bad_pkt_count,
    input  logic [DATA_WBITS-1:0] fpkt_out_tdata,
    input  logic [DATA_WBYTS-1:0] fpkt_out_tkeep,
    input  logic                  fpkt_out_tlast,
    input  logic                  fpkt_out_tvalid,
    output logic                  fpkt_out_tready,
    input  logic [BPI_WBITS-1:0]  fbpi_out_tdata,
    input  logic                  fbpi_out_tvalid,
    output logic                  fbpi_out_tready,
    output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
    output logic [DATA_WBYTS-1:0] AXIS_OUT_TKEEP,
    output logic                  AXIS_OUT_TLAST,
    output logic                  AXIS_OUT_TVALID,
    input  logic                  AXIS_OUT_TREADY
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_WBITS-1:0] CNT_ONE = CNT_WBITS'(1);
    localparam logic [CNT_WBITS-1:0] CNT_MAX = '1;

    state_t               r_state;
    logic                 r_bad;
    logic                 r_dropped;
    logic [CNT_WBITS-1:0] r_goodCnt;
    logic [CNT_WBITS-1:0] r_badCnt;

    logic w_badNow;
    logic w_bothValid;
    logic w_first;
    logic w_goodEvt;
    logic w_badEvt;
    logic w_xferLast;
    logic w_drainLast;

    assign AXIS_OUT_TDATA  = fpkt_out_tdata;
    assign AXIS_OUT_TKEEP  = fpkt_out_tkeep;
    assign AXIS_OUT_TLAST  = fpkt_out_tlast;

    assign bad_pkt_dropped = r_dropped;
    assign good_pkt_count  = r_goodCnt;
    assign bad_pkt_count   = r_badCnt;

    // A bad first beat is consumed regardless of downstream readiness.
    assign w_badNow    = |(fbpi_out_tdata & error_mask);
    assign w_bothValid = fbpi_out_tvalid & fpkt_out_tvalid;
    assign w_first     = (r_state == ST_WAIT) & w_bothValid & (w_badNow | AXIS_OUT_TREADY);
    assign w_goodEvt   = w_first & ~w_badNow;
    assign w_badEvt    = w_first & w_badNow;

    assign w_xferLast  = fpkt_out_tvalid & fpkt_out_tready & fpkt_out_tlast;
    assign w_drainLast = w_xferLast;

    always_comb begin
        fpkt_out_tready = 1'b0;
        fbpi_out_tready = 1'b0;
        AXIS_OUT_TVALID = 1'b0;
        unique case (r_state)
            ST_WAIT: begin
                fpkt_out_tready = w_first;
                fbpi_out_tready = w_first;
                AXIS_OUT_TVALID = w_bothValid & ~w_badNow;
            end
            ST_XFER: begin
                fpkt_out_tready = r_bad | AXIS_OUT_TREADY;
                AXIS_OUT_TVALID = fpkt_out_tvalid & ~r_bad;
            end
            ST_DRAIN: begin
                fpkt_out_tready = 1'b1;
            end
            default: begin
                fpkt_out_tready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_INIT;
            r_bad   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_INIT: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_first) begin
                        r_bad <= w_badNow;
                        if (!fpkt_out_tlast) begin
                            r_state <= w_badNow ? ST_DRAIN : ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_xferLast) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (w_drainLast) begin
                        r_state <= ST_WAIT;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // A clear coinciding with a packet start restarts the count at that packet, not zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_goodCnt <= '0;
            r_badCnt  <= '0;
            r_dropped <= 1'b0;
        end else if (clear_stats) begin
            r_goodCnt <= w_goodEvt ? CNT_ONE : '0;
            r_badCnt  <= w_badEvt ? CNT_ONE : '0;
            r_dropped <= w_badEvt;
        end else begin
            if (w_goodEvt && (r_goodCnt != CNT_MAX)) begin
                r_goodCnt <= r_goodCnt + CNT_ONE;
            end
            if (w_badEvt) begin
                r_dropped <= 1'b1;
                if (r_badCnt != CNT_MAX) begin
                    r_badCnt <= r_badCnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_error_filter.sv
// Scoreboard bench for packet_error_filter: directed packets feed modelled FIFOs, a
// monitor checks every AXIS_OUT handshake against the expected-beat queue.
module tb_packet_error_filter;

    localparam int DW = 32;
    localparam int DB = DW / 8;
    localparam int BW = 8;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk;
    logic          resetn;
    logic [BW-1:0] error_mask;
    logic          clear_stats;
    logic          bad_pkt_dropped;
    logic [CW-1:0] good_pkt_count;
    logic [CW-1:0] bad_pkt_count;
    logic [DW-1:0] fpkt_out_tdata;
    logic [DB-1:0] fpkt_out_tkeep;
    logic          fpkt_out_tlast;
    logic          fpkt_out_tvalid;
    logic          fpkt_out_tready;
    logic [BW-1:0] fbpi_out_tdata;
    logic          fbpi_out_tvalid;
    logic          fbpi_out_tready;
    logic [DW-1:0] AXIS_OUT_TDATA;
    logic [DB-1:0] AXIS_OUT_TKEEP;
    logic          AXIS_OUT_TLAST;
    logic          AXIS_OUT_TVALID;
    logic          AXIS_OUT_TREADY;

    beat_t         pktQ[$];
    logic [BW-1:0] bpiQ[$];
    beat_t         sbQ[$];

    int    testsRun = 0;
    int    testsFailed = 0;
    int    readyMode = 0;
    bit    toggleBit = 0;
    bit    clearReq = 0;
    bit    clearWithNext = 0;
    bit    hsPkt = 0;
    bit    hsBpi = 0;
    int    cyc = 0;
    int    hsTotal = 0;
    int    hsFirstCyc = -1;
    int    hsLastCyc = -1;
    bit    sawValid = 0;
    bit    prevStall = 0;
    logic [DW-1:0] prevData;
    beat_t expBeat;

    packet_error_filter #(
        .DATA_WBITS(DW),
        .DATA_WBYTS(DB),
        .BPI_WBITS (BW),
        .CNT_WBITS (CW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .error_mask     (error_mask),
        .clear_stats    (clear_stats),
        .bad_pkt_dropped(bad_pkt_dropped),
        .good_pkt_count (good_pkt_count),
        .bad_pkt_count  (bad_pkt_count),
        .fpkt_out_tdata (fpkt_out_tdata),
        .fpkt_out_tkeep (fpkt_out_tkeep),
        .fpkt_out_tlast (fpkt_out_tlast),
        .fpkt_out_tvalid(fpkt_out_tvalid),
        .fpkt_out_tready(fpkt_out_tready),
        .fbpi_out_tdata (fbpi_out_tdata),
        .fbpi_out_tvalid(fbpi_out_tvalid),
        .fbpi_out_tready(fbpi_out_tready),
        .AXIS_OUT_TDATA (AXIS_OUT_TDATA),
        .AXIS_OUT_TKEEP (AXIS_OUT_TKEEP),
        .AXIS_OUT_TLAST (AXIS_OUT_TLAST),
        .AXIS_OUT_TVALID(AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY(AXIS_OUT_TREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int pktId, input int nBeats, input logic [BW-1:0] bpi, input bit expGood);
        beat_t b;
        for (int i = 0; i < nBeats; i++) begin
            b.data = {8'(pktId), 8'hA5, 16'(i)};
            b.last = (i == nBeats - 1);
            b.keep = b.last ? 4'h3 : 4'hF;
            pktQ.push_back(b);
            if (expGood) sbQ.push_back(b);
        end
        bpiQ.push_back(bpi);
    endtask

    task automatic waitIdle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (pktQ.size() == 0 && bpiQ.size() == 0 && sbQ.size() == 0) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timeout, %0d beats left, expected 0", name, pktQ.size() + sbQ.size());
    endtask

    task automatic checkStats(input string name, input int expGood, input int expBad, input int expFlag);
        checkOutput({name, "_good"}, 32'(good_pkt_count), 32'(expGood));
        checkOutput({name, "_bad"}, 32'(bad_pkt_count), 32'(expBad));
        checkOutput({name, "_flag"}, 32'(bad_pkt_dropped), 32'(expFlag));
    endtask

    // Upstream FIFO model: pops on the handshakes seen by the monitor, then presents the next head.
    initial begin
        fpkt_out_tdata  = '0;
        fpkt_out_tkeep  = '0;
        fpkt_out_tlast  = 1'b0;
        fpkt_out_tvalid = 1'b0;
        fbpi_out_tdata  = '0;
        fbpi_out_tvalid = 1'b0;
        AXIS_OUT_TREADY = 1'b0;
        clear_stats     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hsPkt && pktQ.size() > 0) expBeat = pktQ.pop_front();
            if (hsBpi && bpiQ.size() > 0) fbpi_out_tdata = bpiQ.pop_front();
            case (readyMode)
                0: AXIS_OUT_TREADY = 1'b1;
                1: AXIS_OUT_TREADY = 1'b0;
                default: begin
                    toggleBit = ~toggleBit;
                    AXIS_OUT_TREADY = toggleBit;
                end
            endcase
            clear_stats = 1'b0;
            if (clearReq) begin
                clear_stats = 1'b1;
                clearReq = 0;
            end else if (clearWithNext && pktQ.size() > 0) begin
                clear_stats = 1'b1;
                clearWithNext = 0;
            end
            fpkt_out_tvalid = (pktQ.size() > 0);
            if (pktQ.size() > 0) begin
                fpkt_out_tdata = pktQ[0].data;
                fpkt_out_tkeep = pktQ[0].keep;
                fpkt_out_tlast = pktQ[0].last;
            end else begin
                fpkt_out_tdata = '0;
                fpkt_out_tkeep = '0;
                fpkt_out_tlast = 1'b0;
            end
            fbpi_out_tvalid = (bpiQ.size() > 0);
            fbpi_out_tdata  = (bpiQ.size() > 0) ? bpiQ[0] : '0;
        end
    end

    // Upstream FIFOs share the reset, so pending traffic vanishes with it.
    always @(negedge resetn) begin
        pktQ.delete();
        bpiQ.delete();
        sbQ.delete();
    end

    always @(negedge clk) begin
        if (!resetn) begin
            hsPkt = 0;
            hsBpi = 0;
            prevStall = 0;
        end else begin
            cyc++;
            hsPkt = fpkt_out_tvalid & fpkt_out_tready;
            hsBpi = fbpi_out_tvalid & fbpi_out_tready;
            if (hsPkt) begin
                hsTotal++;
                if (hsFirstCyc < 0) hsFirstCyc = cyc;
                hsLastCyc = cyc;
            end
            if (AXIS_OUT_TVALID) sawValid = 1;
            if (prevStall) begin
                checkOutput("stall_valid", 32'(AXIS_OUT_TVALID), 32'd1);
                checkOutput("stall_data", AXIS_OUT_TDATA, prevData);
            end
            if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                if (sbQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_beat: got data %0h, expected no beat", AXIS_OUT_TDATA);
                end else begin
                    beat_t e;
                    e = sbQ.pop_front();
                    checkOutput("beat_data", AXIS_OUT_TDATA, e.data);
                    checkOutput("beat_keep", 32'(AXIS_OUT_TKEEP), 32'(e.keep));
                    checkOutput("beat_last", 32'(AXIS_OUT_TLAST), 32'(e.last));
                end
            end
            prevStall = AXIS_OUT_TVALID & ~AXIS_OUT_TREADY;
            prevData  = AXIS_OUT_TDATA;
        end
    end

    initial begin
        resetn     = 1'b0;
        error_mask = 8'h01;
        repeat (3) @(posedge clk);
        #2;
        checkStats("reset", 0, 0, 0);
        checkOutput("reset_tvalid", 32'(AXIS_OUT_TVALID), 32'd0);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Good, bad, good 4-beat packets with downstream always ready
        readyMode = 0;
        applyStimulus(1, 4, 8'h00, 1);
        applyStimulus(2, 4, 8'h01, 0);
        applyStimulus(3, 4, 8'h00, 1);
        waitIdle("t1", 200);
        checkStats("t1", 2, 1, 1);

        // Bad 16-beat packet drained with downstream stalled
        readyMode = 1;
        sawValid = 0;
        hsTotal = 0;
        hsFirstCyc = -1;
        applyStimulus(4, 16, 8'h01, 0);
        waitIdle("t2", 200);
        checkOutput("t2_drain_beats", 32'(hsTotal), 32'd16);
        checkOutput("t2_drain_span", 32'(hsLastCyc - hsFirstCyc), 32'd15);
        checkOutput("t2_no_valid", 32'(sawValid), 32'd0);
        checkStats("t2", 2, 2, 1);

        // Good 6-beat packet against a toggling TREADY
        readyMode = 2;
        applyStimulus(5, 6, 8'h00, 1);
        waitIdle("t3", 200);
        checkStats("t3", 3, 2, 1);

        // Mask selectivity and an all-zero mask
        readyMode = 0;
        error_mask = 8'h0C;
        applyStimulus(6, 2, 8'h02, 1);
        applyStimulus(7, 2, 8'h08, 0);
        waitIdle("t4a", 200);
        error_mask = 8'h00;
        applyStimulus(8, 3, 8'hFF, 1);
        waitIdle("t4b", 200);
        checkStats("t4", 5, 3, 1);

        // Saturation of the 4-bit counter with back-to-back single-beat packets
        clearReq = 1;
        repeat (3) @(negedge clk);
        checkStats("t5_clear", 0, 0, 0);
        hsTotal = 0;
        hsFirstCyc = -1;
        for (int i = 0; i < 20; i++) applyStimulus(16 + i, 1, 8'h00, 1);
        waitIdle("t5a", 300);
        checkOutput("t5_b2b_span", 32'(hsLastCyc - hsFirstCyc), 32'd19);
        checkStats("t5_sat", 15, 0, 0);
        error_mask = 8'h0C;
        clearWithNext = 1;
        applyStimulus(40, 1, 8'h04, 0);
        waitIdle("t5b", 200);
        checkStats("t5_clr_hit", 0, 1, 1);

        // Reset on beat 3 of a 5-beat good packet
        error_mask = 8'h01;
        hsTotal = 0;
        applyStimulus(50, 5, 8'h00, 1);
        for (int i = 0; i < 200 && hsTotal < 2; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("t6_reached_beat3", 32'(hsTotal), 32'd2);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("t6_rst_tvalid", 32'(AXIS_OUT_TVALID), 32'd0);
        checkOutput("t6_rst_pkt_ready", 32'(fpkt_out_tready), 32'd0);
        checkOutput("t6_rst_bpi_ready", 32'(fbpi_out_tready), 32'd0);
        checkStats("t6_rst", 0, 0, 0);
        @(negedge clk);
        applyStimulus(51, 3, 8'h00, 1);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        #1;
        checkOutput("t6_init_in_valid", 32'(fpkt_out_tvalid), 32'd1);
        checkOutput("t6_init_pkt_ready", 32'(fpkt_out_tready), 32'd0);
        checkOutput("t6_init_tvalid", 32'(AXIS_OUT_TVALID), 32'd0);
        waitIdle("t6", 200);
        checkStats("t6_after", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
